// File: rtl/tsb_bus_arb.sv
// tsb_bus_arb: registered tristate bus driver / arbiter for the shared datapath bus.
//
// Each source raises its bit in `gate`. A single requester becomes the registered
// one-hot `owner` and its slice of `din` is placed on `bus`. A direct handoff
// between two owners inserts TURNAROUND idle cycles (break-before-make). A
// multi-hot request never reaches the wire. Instead the block parks in FAULT and
// raises the sticky `conflict` flag.
//
// Parameters:
//   WIDTH      - bus width in bits
//   SOURCES    - number of drivers (2..16)
//   TURNAROUND - idle cycles on a direct owner-to-owner handoff (0..15)
//
// Ports:
//   clk          - clock, rising edge
//   rst_n        - synchronous active-low reset
//   gate         - per-source drive requests
//   din          - source data, source i at [i*WIDTH +: WIDTH]
//   conflict_clr - clears the sticky conflict flag
//   bus          - tristate bus output
//   owner        - registered one-hot owner, 0 when nobody drives
//   busy         - high in DRIVE or TURN
//   conflict     - sticky multi-driver flag
//
// Optional feature: define TSB_BUS_KEEPER_EN to hold the last driven value on
// `bus` in non-DRIVE states instead of floating it.

module tsb_bus_arb #(
  parameter int WIDTH      = 16,
  parameter int SOURCES    = 4,
  parameter int TURNAROUND = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [SOURCES-1:0]         gate,
  input  logic [SOURCES*WIDTH-1:0]   din,
  input  logic                       conflict_clr,
  output logic [WIDTH-1:0]           bus,
  output logic [SOURCES-1:0]         owner,
  output logic                       busy,
  output logic                       conflict
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Counter value loaded on entry to TURN. The zero case is unused because
  // TURNAROUND = 0 hands off directly without entering TURN.
  localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;

  state_t               state, state_n;
  logic [SOURCES-1:0]   owner_n;
  logic [3:0]           cnt, cnt_n;
  logic                 gate_zero, gate_onehot, gate_multi;
  logic [WIDTH-1:0]     sel_data;

  // x & (x-1) clears the lowest set bit, so a nonzero result means two or more bits are set.
  assign gate_zero   = (gate == '0);
  assign gate_multi  = ((gate & (gate - SOURCES'(1))) != '0);
  assign gate_onehot = !gate_zero && !gate_multi;

  // Owner is one-hot or zero, so OR-ing the masked slices is a clean mux.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (owner[i]) sel_data = sel_data | din[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    if (gate_multi) begin
      // Contention overrides every other transition, including TURN countdown.
      state_n = FAULT;
      owner_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (gate_onehot) begin
            state_n = DRIVE;
            owner_n = gate;
          end
        end
        DRIVE: begin
          if (gate_zero) begin
            state_n = IDLE;
            owner_n = '0;
          end else if (gate != owner) begin
            if (TURNAROUND > 0) begin
              state_n = TURN;
              owner_n = '0;
              cnt_n   = TURN_LOAD;
            end else begin
              owner_n = gate;
            end
          end
        end
        TURN: begin
          // Requests are only looked at when the countdown has expired.
          if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
          end else if (gate_onehot) begin
            state_n = DRIVE;
            owner_n = gate;
          end else begin
            state_n = IDLE;
          end
        end
        FAULT: begin
          // Must pass through IDLE, so a released fault always yields a Z cycle.
          if (gate_zero) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          owner_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
    end
  end

  // Set has priority over clear so a conflict in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else if (gate_multi) begin
      conflict <= 1'b1;
    end else if (conflict_clr) begin
      conflict <= 1'b0;
    end
  end

  assign busy = (state == DRIVE) || (state == TURN);

`ifdef TSB_BUS_KEEPER_EN
  logic [WIDTH-1:0] keeper;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      keeper <= '0;
    end else if (state == DRIVE) begin
      keeper <= sel_data;
    end
  end

  assign bus = (state == DRIVE) ? sel_data : keeper;
`else
  assign bus = (state == DRIVE) ? sel_data : {WIDTH{1'bz}};
`endif

endmodule
